pll_cen_gen: RTL and testbench
==============================

Name: pll_cen_gen

Overview:
- Parametrised successor to the fixed-ratio core PLL wrapper. It runs entirely in the PLL output domain.
- From the single PLL output clock it derives CHANNELS independent fractional clock enables, each at rate refclk*num/den. Example uses: colour clock, CPU enable, audio enable.
- Ratios can be reprogrammed at runtime through a valid/ready handshake.
- A settle counter drives a locked output, replacing the static PLL-only lock.

Parameters:
CHANNELS, 2, number of independent enable channels (1..8)
ACC_W, 32, width of num/den/accumulator per channel
LOCK_CYCLES, 16, refclk cycles locked stays low after reset or any reconfiguration (>=1)

Ports:
refclk  input  1  clock, the PLL output clock
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  config request
cfg_ready  output  1  block can accept config
cfg_chan  input  max(1,$clog2(CHANNELS))  channel index
cfg_num  input  ACC_W  enable numerator
cfg_den  input  ACC_W  enable denominator
cfg_err  output  1  last accepted config rejected (sticky until next accept)
cen  output  CHANNELS  per-channel clock enable, single-cycle pulses
locked  output  1  all enables stable and valid

Behaviour:
- Reset values:
  - cen=0, locked=0, cfg_ready=0, cfg_err=0.
  - All num=0, den=1, accumulators=0.
  - FSM=SETTLE, settle counter=0.
- Async assertion of rst_n clears all of the above immediately. Deassertion is used synchronously; the system provides the synchroniser.
- FSM states:
  - IDLE: cfg_ready=1, locked=1.
  - APPLY: one cycle; cfg_ready=0, locked=0.
  - SETTLE: cfg_ready=0, locked=0.
- Transitions:
  - IDLE -> APPLY on cfg_valid&cfg_ready.
  - APPLY -> SETTLE always.
  - SETTLE -> IDLE when the counter reaches LOCK_CYCLES-1; counter clears on entry.
- Handshake: a transfer occurs only when cfg_valid and cfg_ready are both high on a rising edge. cfg_* is sampled in that cycle. cfg_valid outside IDLE is ignored and not queued.
- APPLY:
  - If cfg_den==0, or cfg_num>cfg_den, or cfg_chan>=CHANNELS: cfg_err=1, no channel state changes, FSM still passes through SETTLE.
  - Otherwise the selected channel loads num/den, its accumulator clears to 0, and cfg_err=0.
  - Other channels keep running; their accumulators are untouched.
- Accumulator, every cycle per channel, computed in ACC_W+1 bits so there is no overflow:
  - s = acc + num.
  - If s >= den: acc <= s - den, cen_i <= locked_next.
  - Else: acc <= s, cen_i <= 0.
- cen is registered; there is one cycle latency from the accumulator step.
- cen is forced to 0 whenever locked is 0. Accumulators keep running during SETTLE.
- num==den gives cen=1 every locked cycle. num==0 gives cen=0 permanently.
- Long-term exactness: over den cycles exactly num pulses. There is no drift and no rounding.
- Reset mid-APPLY or mid-SETTLE: full reset values; pending config is lost.

Optional Feature:
- Macro: PLL_CEN_SYNC_EN.
- Defined:
  - Adds input port sync_clr (1 bit).
  - A cycle with sync_clr=1 clears all channel accumulators to 0 and forces all cen to 0 for the following cycle, phase-aligning every channel.
  - sync_clr does not affect FSM, locked or cfg_err.
  - If it coincides with APPLY, the load wins for the selected channel (accumulator=0 either way) and the other channels clear.
- Undefined: port absent; accumulators clear only on reset or per-channel APPLY.

Test Plan:
- Reset, no config: locked low for exactly LOCK_CYCLES=16 cycles after rst_n rises, then 1; cfg_ready rises together with locked; cen stays 0.
- Config ch0 num=1 den=3: cfg_ready drops the cycle after handshake; locked returns after APPLY+16 cycles; then cen[0] repeats pattern 0,0,1 with period exactly 3; cen[1] remains 0.
- Config ch1 num=7 den=100 (lock settled): count cen[1] over 1000 locked cycles -> exactly 70 pulses, never two adjacent.
- Config den=0, then num=5 den=4, then cfg_chan=CHANNELS: each sets cfg_err=1; channel outputs unchanged. A following valid config clears cfg_err.
- Hold cfg_valid high through SETTLE with changing data: only the value present at the IDLE handshake cycle is applied; exactly one APPLY per IDLE visit.
- Assert rst_n=0 for 1 cycle during SETTLE of ch0 num=2 den=3: cen=0 and locked=0 immediately, num returns to 0; after 16 cycles locked=1 and no cen pulses (with PLL_CEN_SYNC_EN: sync_clr mid-run on num=1 den=3 -> next two cen 0, third 1).

Source files
------------

// File: rtl/pll_cen_gen.sv
// -----------------------------------------------------------------------------
// pll_cen_gen
//
// Purpose:
//   Derives CHANNELS independent fractional clock enables from the PLL output
//   clock. Each channel has its own rate of refclk*num/den. Every ratio can be
//   reprogrammed at runtime through a valid/ready handshake. After reset, and
//   after every reconfiguration, a settle counter holds `locked` low for
//   LOCK_CYCLES cycles.
//
// Parameters:
//   CHANNELS    - number of enable channels (1..8)
//   ACC_W       - width of the num/den/accumulator of each channel
//   LOCK_CYCLES - cycles that locked stays low after reset or reconfig (>=1)
//
// Ports:
//   refclk    in   PLL output clock (the only clock domain)
//   rst_n     in   asynchronous active-low reset (deassertion is pre-synchronised)
//   cfg_valid in   configuration request
//   cfg_ready out  high in IDLE, when a configuration can be accepted
//   cfg_chan  in   channel index of the request
//   cfg_num   in   enable numerator
//   cfg_den   in   enable denominator
//   cfg_err   out  last accepted configuration was rejected (sticky until next)
//   cen       out  per-channel single-cycle enable pulses
//   locked    out  all enables stable and valid
//   sync_clr  in   (only with PLL_CEN_SYNC_EN) clears every accumulator and
//                  blanks every cen for one cycle, phase-aligning all channels
//
// Optional feature macro: PLL_CEN_SYNC_EN (adds the sync_clr port).
// -----------------------------------------------------------------------------
module pll_cen_gen #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] cen,
  output logic                locked
`ifdef PLL_CEN_SYNC_EN
  , input logic               sync_clr
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                handshake;
  logic                cfg_bad;
  logic                locked_d;
  logic                apply_ok;

  // The request is captured at the handshake and applied one cycle later, so
  // whatever cfg_* does during APPLY/SETTLE cannot affect it.
  logic [CHAN_W-1:0]   pend_chan_q;
  logic [ACC_W-1:0]    pend_num_q;
  logic [ACC_W-1:0]    pend_den_q;
  logic                pend_bad_q;
  logic                err_q;

  assign cfg_ready = (state_q == ST_IDLE);
  assign locked    = (state_q == ST_IDLE);
  assign cfg_err   = err_q;
  assign handshake = cfg_valid & cfg_ready;
  assign cfg_bad   = (cfg_den == '0) || (cfg_num > cfg_den) ||
                     (int'(cfg_chan) >= CHANNELS);
  assign apply_ok  = (state_q == ST_APPLY) && !pend_bad_q;

  // locked_d is the value locked will have after this edge. Each channel's
  // registered cen is qualified by it, so cen is never high while locked is low.
  assign locked_d  = (state_d == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) state_d = ST_IDLE;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      pend_chan_q <= '0;
      pend_num_q  <= '0;
      pend_den_q  <= '0;
      pend_bad_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (handshake) begin
        pend_chan_q <= cfg_chan;
        pend_num_q  <= cfg_num;
        pend_den_q  <= cfg_den;
        pend_bad_q  <= cfg_bad;
      end
      if (state_q == ST_APPLY) err_q <= pend_bad_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel fractional accumulator. The sum is one bit wider than the
  // accumulator; since acc < den and num <= den, s - den always fits ACC_W.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [ACC_W-1:0] num_q, den_q, acc_q;
      logic             cen_q;
      logic [ACC_W:0]   sum;
      logic [ACC_W:0]   diff;
      logic             hit;
      logic             load;

      assign sum  = {1'b0, acc_q} + {1'b0, num_q};
      assign diff = sum - {1'b0, den_q};
      assign hit  = (sum >= {1'b0, den_q});
      assign load = apply_ok && (pend_chan_q == CHAN_W'(gi));

      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          num_q <= '0;
          den_q <= {{(ACC_W-1){1'b0}}, 1'b1};
          acc_q <= '0;
          cen_q <= 1'b0;
        end else if (load) begin
          // locked_d is low in APPLY, so no pulse is lost or invented here.
          num_q <= pend_num_q;
          den_q <= pend_den_q;
          acc_q <= '0;
          cen_q <= 1'b0;
`ifdef PLL_CEN_SYNC_EN
        end else if (sync_clr) begin
          acc_q <= '0;
          cen_q <= 1'b0;
`endif
        end else if (hit) begin
          acc_q <= diff[ACC_W-1:0];
          cen_q <= locked_d;
        end else begin
          acc_q <= sum[ACC_W-1:0];
          cen_q <= 1'b0;
        end
      end

      assign cen[gi] = cen_q;
    end
  endgenerate

endmodule

// File: tb/tb_pll_cen_gen.sv
// -----------------------------------------------------------------------------
// tb_pll_cen_gen
//
// Purpose: self-checking bench for pll_cen_gen (CHANNELS=3 so that an
// out-of-range channel index can be presented, ACC_W=32, LOCK_CYCLES=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just passed.
// -----------------------------------------------------------------------------
module tb_pll_cen_gen;

  localparam int CH = 3;
  localparam int AW = 32;
  localparam int LC = 16;

  logic          refclk = 1'b0;
  logic          rst_n  = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_chan  = '0;
  logic [AW-1:0] cfg_num   = '0;
  logic [AW-1:0] cfg_den   = '0;
  logic          cfg_ready;
  logic          cfg_err;
  logic [CH-1:0] cen;
  logic          locked;
`ifdef PLL_CEN_SYNC_EN
  logic          sync_clr = 1'b0;
`endif

  int nvec  = 0;
  int nfail = 0;

  always #5 refclk = ~refclk;

  pll_cen_gen #(
    .CHANNELS   (CH),
    .ACC_W      (AW),
    .LOCK_CYCLES(LC)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_num  (cfg_num),
    .cfg_den  (cfg_den),
    .cfg_err  (cfg_err),
    .cen      (cen),
    .locked   (locked)
`ifdef PLL_CEN_SYNC_EN
    , .sync_clr(sync_clr)
`endif
  );

  typedef struct {
    int         reps;
    logic       valid;
    logic [1:0] chan;
    logic [31:0] num;
    logic [31:0] den;
    logic       rdy;
    logic       lck;
    logic [2:0] cen;
    logic       err;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] n, input logic [31:0] d);
    cfg_valid = v;
    cfg_chan  = c;
    cfg_num   = n;
    cfg_den   = d;
  endtask

  // Bounded wait for locked; an expired bound shows up as a failed compare.
  task automatic wait_lock(input string name);
    for (int i = 0; i < 40 && !locked; i++) step();
    chk(name, 32'(locked), 32'd1);
  endtask

  task automatic count_cen(input int cycles, output int c0, output int c1, output int c2,
                           output int adj1);
    logic prev1;
    c0 = 0; c1 = 0; c2 = 0; adj1 = 0; prev1 = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      c0 += int'(cen[0]);
      c1 += int'(cen[1]);
      c2 += int'(cen[2]);
      if (cen[1] && prev1) adj1++;
      prev1 = cen[1];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, adj, low, rdy;
    logic [1:0]  bad_chan[3];
    logic [31:0] bad_num[3];
    logic [31:0] bad_den[3];

    // Cycle-by-cycle vectors from reset release through the first ch0 config.
    // cen[0] for num=1/den=3 after lock: 0,0,1 repeating.
    tbl = '{
      '{15, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'b000, 1'b0},  // settling after reset
      '{ 1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b000, 1'b0},  // lock + ready together
      '{ 4, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b000, 1'b0},  // idle, num=0 -> no cen
      '{ 1, 1'b1, 2'd0, 32'd1, 32'd3, 1'b0, 1'b0, 3'b000, 1'b0},  // handshake -> APPLY
      '{16, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'b000, 1'b0},  // SETTLE
      '{ 2, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b000, 1'b0},
      '{ 1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b001, 1'b0},
      '{ 2, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b000, 1'b0},
      '{ 1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b001, 1'b0},
      '{ 2, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b000, 1'b0},
      '{ 1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 1'b1, 3'b001, 1'b0}
    };

    bad_chan = '{2'd1, 2'd0, 2'd3};
    bad_num  = '{32'd1, 32'd5, 32'd1};
    bad_den  = '{32'd0, 32'd4, 32'd1};

    // Reset state while rst_n is held low.
    step();
    step();
    chk("reset_state", {26'd0, cfg_ready, locked, cen, cfg_err}, 32'd0);
    rst_n = 1'b1;

    // Table-driven part.
    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        drive(tbl[r].valid, tbl[r].chan, tbl[r].num, tbl[r].den);
        step();
        chk($sformatf("row%0d.%0d {rdy,lck,cen,err}", r, k),
            {26'd0, cfg_ready, locked, cen, cfg_err},
            {26'd0, tbl[r].rdy, tbl[r].lck, tbl[r].cen, tbl[r].err});
      end
    end
    drive(1'b0, 2'd0, 32'd0, 32'd0);

    // ch1 = 7/100: exactly 70 pulses in 1000 locked cycles, never adjacent.
    drive(1'b1, 2'd1, 32'd7, 32'd100);
    step();
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    wait_lock("ch1_lock");
    count_cen(1000, c0, c1, c2, adj);
    chk("ch1_pulses_1000", c1, 32'd70);
    chk("ch1_adjacent", adj, 32'd0);
    chk("ch2_idle_pulses", c2, 32'd0);

    // Rejected configurations: err set and sticky, channels keep running.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, bad_chan[k], bad_num[k], bad_den[k]);
      step();
      drive(1'b0, 2'd0, 32'd0, 32'd0);
      step();
      chk($sformatf("bad%0d_err_set", k), 32'(cfg_err), 32'd1);
      wait_lock($sformatf("bad%0d_lock", k));
      chk($sformatf("bad%0d_err_sticky", k), 32'(cfg_err), 32'd1);
      count_cen(300, c0, c1, c2, adj);
      chk($sformatf("bad%0d_ch0_pulses", k), c0, 32'd100);
      chk($sformatf("bad%0d_ch1_pulses", k), c1, 32'd21);
      chk($sformatf("bad%0d_ch2_pulses", k), c2, 32'd0);
    end

    // Valid config clears err; num==den gives cen every locked cycle.
    drive(1'b1, 2'd2, 32'd1, 32'd1);
    step();
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    step();
    chk("good_err_clear", 32'(cfg_err), 32'd0);
    wait_lock("good_lock");
    count_cen(10, c0, c1, c2, adj);
    chk("ch2_num_eq_den", c2, 32'd10);

    // cfg_valid held through SETTLE with changing data: only the handshake
    // value (ch2 = 1/2) is applied, and one APPLY per IDLE visit.
    drive(1'b1, 2'd2, 32'd1, 32'd2);
    step();
    low = 0;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive(1'b1, 2'd2, 32'd0, 32'd1);
      else            drive(1'b1, 2'd2, 32'd3, 32'd5);
      step();
      if (cfg_ready) break;
      low++;
    end
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    chk("hold_settle_cycles", low, 32'd16);
    rdy = 0;
    c2  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      rdy += int'(cfg_ready);
      c2  += int'(cen[2]);
    end
    chk("hold_single_apply", rdy, 32'd20);
    chk("hold_ch2_half_rate", c2, 32'd10);

    // Asynchronous reset in SETTLE of ch0 = 2/3.
    drive(1'b1, 2'd0, 32'd2, 32'd3);
    step();
    drive(1'b0, 2'd0, 32'd0, 32'd0);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {26'd0, cfg_ready, locked, cen, cfg_err}, 32'd0);
    @(posedge refclk);
    @(negedge refclk);
    rst_n = 1'b1;
    low = 0;
    for (int i = 0; i < LC - 1; i++) begin
      step();
      if (!locked) low++;
    end
    chk("rst_locked_low", low, 32'(LC - 1));
    step();
    chk("rst_locked_high", 32'(locked), 32'd1);
    count_cen(30, c0, c1, c2, adj);
    chk("rst_no_cen", c0 + c1 + c2, 32'd0);

`ifdef PLL_CEN_SYNC_EN
    // sync_clr on ch0 = 1/3: the blanked cycle, then the two steps from acc=0
    // that do not reach den, then the pulse.
    begin
      logic [3:0] exp_seq;
      exp_seq = 4'b1000;
      drive(1'b1, 2'd0, 32'd1, 32'd3);
      step();
      drive(1'b0, 2'd0, 32'd0, 32'd0);
      wait_lock("sync_lock");
      count_cen(7, c0, c1, c2, adj);
      sync_clr = 1'b1;
      step();
      sync_clr = 1'b0;
      chk("sync_cen0_0", 32'(cen[0]), 32'(exp_seq[0]));
      for (int i = 1; i < 4; i++) begin
        step();
        chk($sformatf("sync_cen0_%0d", i), 32'(cen[0]), 32'(exp_seq[i]));
      end
      chk("sync_locked", 32'(locked), 32'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
